fft_frame_feeder: RTL and testbench

Frame feeder that drives the FFT core's AXI4-Stream input side: it accepts a continuous real-valued audio sample stream without backpressure, collects 2^LOG2_FFT_LEN samples into a ping-pong buffer, then issues one config beat and streams the frame as complex words with tlast, honouring tready. It sits between the audio capture path and the FFT wrapper's data/cfg inputs.

---
 rtl/fft_feeder_pkg.sv | 22 ++
 rtl/fft_feeder_dpram.sv | 26 ++
 rtl/fft_frame_feeder.sv | 167 ++++++++++++++++
 tb/tb_fft_frame_feeder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft_feeder_pkg.sv
// Shared definitions for the FFT frame feeder: reader FSM encoding,
// byte-aligned lane width derivation and tdata lane placement.
package fft_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CFG    = 2'd1,
    ST_STREAM = 2'd2
  } rd_state_e;

  // Real/imag lanes are each rounded up to a whole number of bytes.
  function automatic int datain_width(input int w);
    return ((w + 7) / 8) * 8;
  endfunction

  localparam int RE_LANE_LSB = 0;

  function automatic int im_lane_lsb(input int dw);
    return dw;
  endfunction

endpackage

// File: rtl/fft_feeder_dpram.sv
// Simple dual-port RAM, one write and one registered read port (latency 1).
// No reset on the array or read register so it maps onto block RAM.
module fft_feeder_dpram #(
  parameter int AW = 4,
  parameter int W  = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_frame_feeder.sv
// Collects N real samples into a ping-pong buffer, then emits a config beat
// and streams the frame as complex AXI4-Stream words with tlast.
module fft_frame_feeder
  import fft_feeder_pkg::*;
#(
  parameter int LOG2_FFT_LEN = 10,
  parameter int INPUT_WIDTH  = 16
) (
  input  logic                                   i_aclk,
  input  logic                                   i_rstn,
  input  logic                                   i_sample_vld,
  input  logic [INPUT_WIDTH-1:0]                 i_sample,
  input  logic                                   i_fft_mode,
  output logic                                   o_axi4s_cfg_tvalid,
  output logic                                   o_axi4s_cfg_tdata,
  output logic                                   o_axi4s_data_tvalid,
  output logic [2*datain_width(INPUT_WIDTH)-1:0] o_axi4s_data_tdata,
  output logic                                   o_axi4s_data_tlast,
  input  logic                                   i_axi4s_data_tready,
  output logic                                   o_ovf,
  output logic                                   o_busy
);

  localparam int DATAIN_WIDTH = datain_width(INPUT_WIDTH);
  localparam int IM_LSB       = im_lane_lsb(DATAIN_WIDTH);
  localparam int AW           = LOG2_FFT_LEN + 1;
  localparam logic [LOG2_FFT_LEN-1:0] IDX_LAST = '1;

  // ---------------- writer ----------------
  logic                    wr_bank;
  logic [LOG2_FFT_LEN-1:0] wr_idx;
  logic [1:0]              bank_full, bank_mode;
  logic [1:0]              set_full, clr_full;
  logic                    wr_en, wr_done;

  assign wr_en    = i_sample_vld && !bank_full[wr_bank];
  assign wr_done  = wr_en && (wr_idx == IDX_LAST);
  assign set_full = 2'(wr_done) << wr_bank;

  always_ff @(posedge i_aclk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_idx    <= '0;
      wr_bank   <= 1'b0;
      bank_full <= '0;
      bank_mode <= '0;
      o_ovf     <= 1'b0;
    end else begin
      o_ovf     <= i_sample_vld && bank_full[wr_bank];
      // set and clear never hit the same bank: set needs empty, clear needs full
      bank_full <= (bank_full | set_full) & ~clr_full;
      if (wr_en) begin
        wr_idx <= wr_idx + 1'b1;
        if (wr_done) begin
          bank_mode[wr_bank] <= i_fft_mode;
          wr_bank            <= ~wr_bank;
        end
      end
    end
  end

  // ---------------- reader FSM ----------------
  rd_state_e state_q, state_d;
  logic      rd_bank;
  logic      out_vld, out_last, skid_vld, skid_last;
  logic      pop, rel;

  assign pop      = out_vld && i_axi4s_data_tready;
  assign rel      = pop && out_last;
  assign clr_full = 2'(rel) << rd_bank;

  always_ff @(posedge i_aclk or negedge i_rstn) begin
    if (!i_rstn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (bank_full[rd_bank]) state_d = ST_CFG;
      ST_CFG:    state_d = ST_STREAM;
      ST_STREAM: if (rel) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign o_axi4s_cfg_tvalid = (state_q == ST_CFG);
  assign o_axi4s_cfg_tdata  = (state_q == ST_CFG) && bank_mode[rd_bank];
  assign o_busy             = (state_q != ST_IDLE);

  // ---------------- prefetch + skid ----------------
  logic [LOG2_FFT_LEN-1:0] rd_idx;
  logic                    rd_done, rd_pend, pend_last, rd_issue;
  logic [1:0]              occ;
  logic [INPUT_WIDTH-1:0]  ram_q;
  logic signed [INPUT_WIDTH-1:0] out_smp, skid_smp;

  // out register + skid + read in flight never exceed two entries
  assign occ      = 2'(out_vld) + 2'(skid_vld) + 2'(rd_pend);
  assign rd_issue = ((state_q == ST_CFG) || (state_q == ST_STREAM && !rd_done))
                    && ((occ - 2'(pop)) < 2'd2);

  fft_feeder_dpram #(.AW(AW), .W(INPUT_WIDTH)) u_ram (
    .clk   (i_aclk),
    .we    (wr_en),
    .waddr ({wr_bank, wr_idx}),
    .wdata (i_sample),
    .re    (rd_issue),
    .raddr ({rd_bank, rd_idx}),
    .rdata (ram_q)
  );

  always_ff @(posedge i_aclk or negedge i_rstn) begin
    if (!i_rstn) begin
      rd_bank   <= 1'b0;
      rd_idx    <= '0;
      rd_done   <= 1'b0;
      rd_pend   <= 1'b0;
      pend_last <= 1'b0;
      out_vld   <= 1'b0;
      out_last  <= 1'b0;
      out_smp   <= '0;
      skid_vld  <= 1'b0;
      skid_last <= 1'b0;
      skid_smp  <= '0;
    end else begin
      rd_pend   <= rd_issue;
      pend_last <= rd_issue && (rd_idx == IDX_LAST);
      if (state_q == ST_IDLE) begin
        rd_idx  <= '0;
        rd_done <= 1'b0;
      end else if (rd_issue) begin
        rd_idx <= rd_idx + 1'b1;
        if (rd_idx == IDX_LAST) rd_done <= 1'b1;
      end
      if (rel) rd_bank <= ~rd_bank;

      if (!out_vld || i_axi4s_data_tready) begin
        if (skid_vld) begin
          out_vld   <= 1'b1;
          out_smp   <= skid_smp;
          out_last  <= skid_last;
          skid_vld  <= rd_pend;
          skid_smp  <= ram_q;
          skid_last <= pend_last;
        end else if (rd_pend) begin
          out_vld  <= 1'b1;
          out_smp  <= ram_q;
          out_last <= pend_last;
        end else begin
          out_vld  <= 1'b0;
          out_last <= 1'b0;
        end
      end else if (rd_pend) begin
        // stalled output: park the arriving word
        skid_vld  <= 1'b1;
        skid_smp  <= ram_q;
        skid_last <= pend_last;
      end
    end
  end

  assign o_axi4s_data_tvalid = out_vld;
  assign o_axi4s_data_tlast  = out_vld && out_last;
  assign o_axi4s_data_tdata[RE_LANE_LSB +: DATAIN_WIDTH] = DATAIN_WIDTH'(out_smp);
  assign o_axi4s_data_tdata[IM_LSB +: DATAIN_WIDTH]      = '0;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Self-checking bench: frame-level scoreboard model of the feeder plus a
// table-driven sign-extension check and directed corner-case sequences.
`timescale 1ns/1ps
module tb_fft_frame_feeder;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        vld = 1'b0, mode = 1'b0, tready = 1'b0;
  logic [15:0] smp = '0;
  logic        cfg_v, cfg_d, tv, tl, ovf, busy;
  logic [31:0] td;

  logic        vld12 = 1'b0;
  logic [11:0] smp12 = '0;
  logic        cfg_v12, cfg_d12, tv12, tl12, ovf12, busy12;
  logic [31:0] td12;

  always #5 clk = ~clk;

  fft_frame_feeder #(.LOG2_FFT_LEN(3), .INPUT_WIDTH(16)) dut (
    .i_aclk(clk), .i_rstn(rstn), .i_sample_vld(vld), .i_sample(smp), .i_fft_mode(mode),
    .o_axi4s_cfg_tvalid(cfg_v), .o_axi4s_cfg_tdata(cfg_d),
    .o_axi4s_data_tvalid(tv), .o_axi4s_data_tdata(td), .o_axi4s_data_tlast(tl),
    .i_axi4s_data_tready(tready), .o_ovf(ovf), .o_busy(busy));

  fft_frame_feeder #(.LOG2_FFT_LEN(3), .INPUT_WIDTH(12)) dut12 (
    .i_aclk(clk), .i_rstn(rstn), .i_sample_vld(vld12), .i_sample(smp12), .i_fft_mode(1'b0),
    .o_axi4s_cfg_tvalid(cfg_v12), .o_axi4s_cfg_tdata(cfg_d12),
    .o_axi4s_data_tvalid(tv12), .o_axi4s_data_tdata(td12), .o_axi4s_data_tlast(tl12),
    .i_axi4s_data_tready(1'b1), .o_ovf(ovf12), .o_busy(busy12));

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // tready driver: 0 = low, 1 = high, 2 = random (high 70%)
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       tready = 1'b0;
      1:       tready = 1'b1;
      default: tready = ($urandom_range(0, 99) < 70);
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model / scoreboard ----------------
  logic [15:0] exp_q[$];
  logic [15:0] part_q[$];
  logic        mode_q[$];
  int          held = 0, beat = 0, ovf_seen = 0, done_edge = 0;
  logic        ovf_exp = 1'b0, stall_prev = 1'b0, tv_prev = 1'b0, prev_tl = 1'b0;
  logic [31:0] prev_td = '0;
  bit          cont = 0, lat_arm = 0;

  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete(); part_q.delete(); mode_q.delete();
      held = 0; beat = 0; ovf_exp = 1'b0; stall_prev = 1'b0; tv_prev = 1'b0; lat_arm = 0;
    end else begin
      chk("ovf", ovf, ovf_exp);
      if (ovf) ovf_seen++;
      if (stall_prev) begin
        chk("stall_tvalid", tv, 1'b1);
        chk("stall_tdata", td, prev_td);
        chk("stall_tlast", tl, prev_tl);
      end
      if (tv || cfg_v) chk("busy", busy, 1'b1);
      if (cfg_v) begin
        if (mode_q.size() == 0) chk("cfg_unexpected", cfg_v, 1'b0);
        else chk("cfg_tdata", cfg_d, mode_q.pop_front());
      end
      if (tv && !tv_prev && lat_arm) begin
        chk("latency", cyc - done_edge, 3);
        lat_arm = 0;
      end
      // writer sees the buffer occupancy before any release at this edge
      ovf_exp = vld && (held == 2);
      if (vld && held < 2) begin
        part_q.push_back(smp);
        if (part_q.size() == 8) begin
          foreach (part_q[i]) exp_q.push_back(part_q[i]);
          part_q.delete();
          mode_q.push_back(mode);
          held++;
          if (cont) begin done_edge = cyc + 1; lat_arm = 1; end
        end
      end
      if (tv && tready) begin
        if (exp_q.size() == 0) chk("beat_unexpected", tv, 1'b0);
        else begin
          chk("tdata", td, {16'h0000, exp_q.pop_front()});
          chk("tlast", tl, beat == 7);
          if (beat == 7) begin beat = 0; held--; end
          else beat++;
        end
      end
      stall_prev = tv && !tready;
      prev_td = td; prev_tl = tl; tv_prev = tv;
    end
  end

  task automatic drive(input logic v, input logic [15:0] s, input logic m);
    @(posedge clk); #1;
    vld = v; smp = s; mode = m;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 16'h0000, 1'b0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_cfg_tvalid"}, cfg_v, 1'b0);
    chk({tag, "_cfg_tdata"},  cfg_d, 1'b0);
    chk({tag, "_tvalid"},     tv, 1'b0);
    chk({tag, "_tdata"},      td, 32'h0);
    chk({tag, "_tlast"},      tl, 1'b0);
    chk({tag, "_ovf"},        ovf, 1'b0);
    chk({tag, "_busy"},       busy, 1'b0);
  endtask

  typedef struct {
    logic [11:0] smp;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int ovf0, t;
    tbl[0] = '{12'h800, 32'h0000_F800};
    tbl[1] = '{12'h7FF, 32'h0000_07FF};
    tbl[2] = '{12'h001, 32'h0000_0001};
    tbl[3] = '{12'hFFF, 32'h0000_FFFF};
    tbl[4] = '{12'h000, 32'h0000_0000};
    tbl[5] = '{12'h123, 32'h0000_0123};
    tbl[6] = '{12'hABC, 32'h0000_FABC};
    tbl[7] = '{12'h400, 32'h0000_0400};

    // reset state
    #1 rstn = 1'b0;
    #2 chk_outputs_zero("reset");
    @(posedge clk); @(posedge clk); #1 rstn = 1'b1;

    // sign extension on the 12-bit instance
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1 vld12 = 1'b1; smp12 = tbl[i].smp;
    end
    @(posedge clk); #1 vld12 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      t = 0;
      @(negedge clk);
      while (!tv12 && t < 50) begin @(negedge clk); t++; end
      chk("sx_tvalid", tv12, 1'b1);
      chk("sx_tdata", td12, tbl[i].exp);
      chk("sx_tlast", tl12, i == 7);
    end

    // mid-frame reset while the output is stalled
    rdy_mode = 0;
    for (int i = 0; i < 8; i++) drive(1'b1, 16'h0050 + 16'(i), 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 16'h0070 + 16'(i), 1'b0);
    drive(1'b0, 16'h0, 1'b0);
    t = 0;
    while (!tv && t < 20) begin idle(1); t++; end
    chk("pre_reset_tvalid", tv, 1'b1);
    @(posedge clk); #1 rstn = 1'b0;
    #1 chk_outputs_zero("midreset");
    @(posedge clk); #1 rstn = 1'b1;
    rdy_mode = 1;
    for (int i = 1; i <= 8; i++) drive(1'b1, 16'(i), 1'b0);
    idle(30);
    chk("reset_frame_drained", exp_q.size(), 0);

    // mode captured at the final sample of each frame
    for (int i = 0; i < 8; i++) drive(1'b1, 16'h0100 + 16'(i), i == 7);
    for (int i = 0; i < 8; i++) drive(1'b1, 16'h0200 + 16'(i), i != 7);
    idle(40);
    chk("mode_frames_drained", exp_q.size(), 0);
    chk("mode_cfg_consumed", mode_q.size(), 0);

    // overflow: both banks full, 17th sample dropped
    rdy_mode = 0;
    ovf0 = ovf_seen;
    for (int i = 1; i <= 17; i++) drive(1'b1, 16'(i), 1'b0);
    idle(4);
    chk("ovf_count", ovf_seen - ovf0, 1);
    rdy_mode = 1;
    idle(40);
    chk("ovf_drained", exp_q.size(), 0);

    // sustained stream with the reader always ready
    cont = 1;
    ovf0 = ovf_seen;
    for (int f = 0; f < 100; f++)
      for (int i = 0; i < 8; i++) begin
        drive(1'b1, 16'($urandom), 1'($urandom_range(0, 1)));
        drive(1'b0, 16'h0, 1'b0);
      end
    idle(20);
    cont = 0;
    chk("cont_no_ovf", ovf_seen - ovf0, 0);
    chk("cont_drained", exp_q.size(), 0);

    // random samples, random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 600; i++)
      drive(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
    drive(1'b0, 16'h0, 1'b0);
    rdy_mode = 1;
    idle(60);
    chk("rand_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
